// File: rtl/pwm_pkg.sv
// Shared encodings, default sizes and the period counter step function for
// the multichannel PWM.
package pwm_pkg;

    localparam logic PWM_EDGE   = 1'b0;
    localparam logic PWM_CENTER = 1'b1;

    localparam int DEF_NUM_CH  = 16;
    localparam int DEF_CNT_W   = 8;
    localparam int DEF_PRESC_W = 4;

    typedef struct packed {
        logic [31:0] cnt;
        logic        down;
        logic        wrap;
    } cnt_step_t;

    // Next counter/direction for one tick; wrap marks a period boundary.
    function automatic cnt_step_t cnt_next(input logic [31:0] cnt,
                                           input logic        down,
                                           input logic [31:0] top,
                                           input logic        mode);
        cnt_step_t s;
        s.cnt  = cnt + 32'd1;
        s.down = 1'b0;
        s.wrap = 1'b0;
        if (mode == PWM_EDGE) begin
            if (cnt >= top) begin
                s.cnt  = '0;
                s.wrap = 1'b1;
            end
        end else if (top == 32'd0) begin
            s.cnt  = '0;
            s.wrap = 1'b1;
        end else if (!down && cnt < top) begin
            s.cnt = cnt + 32'd1;
        end else begin
            s.cnt  = cnt - 32'd1;
            s.down = 1'b1;
            if (cnt <= 32'd1) begin
                s.cnt  = '0;
                s.down = 1'b0;
                s.wrap = 1'b1;
            end
        end
        return s;
    endfunction

endpackage

// File: rtl/pwm_multichannel_timebase.sv
// Shared timebase: prescaler, up/up-down period counter, shadowed period and
// mode, and the registered period_start pulse.
module pwm_timebase
    import pwm_pkg::*;
#(
    parameter int CNT_W   = DEF_CNT_W,
    parameter int PRESC_W = DEF_PRESC_W
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [CNT_W-1:0]   period,
    input  logic [PRESC_W-1:0] prescale,
    input  logic               center_mode,
    output logic [CNT_W-1:0]   cnt,
    output logic               tick,
    output logic               boundary,
    output logic               period_start
);

    logic [PRESC_W-1:0] presc_q, presc_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [CNT_W-1:0]   per_q, per_d;
    logic               down_q, down_d;
    logic               mode_q, mode_d;
    logic               ps_q, ps_d;
    cnt_step_t          step;

    always_comb begin
        tick     = (presc_q == prescale);
        presc_d  = tick ? '0 : presc_q + PRESC_W'(1);
        step     = cnt_next(32'(cnt_q), down_q, 32'(per_q), mode_q);
        boundary = tick & step.wrap;
        cnt_d    = cnt_q;
        down_d   = down_q;
        per_d    = per_q;
        mode_d   = mode_q;
        if (tick) begin
            cnt_d  = CNT_W'(step.cnt);
            down_d = step.down;
        end
        // Period and mode only change where the counter restarts at 0.
        if (boundary) begin
            per_d  = period;
            mode_d = center_mode;
        end
        ps_d = boundary;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_q <= '0;
            cnt_q   <= '0;
            per_q   <= '0;
            down_q  <= 1'b0;
            mode_q  <= PWM_EDGE;
            ps_q    <= 1'b0;
        end else begin
            presc_q <= presc_d;
            cnt_q   <= cnt_d;
            per_q   <= per_d;
            down_q  <= down_d;
            mode_q  <= mode_d;
            ps_q    <= ps_d;
        end
    end

    assign cnt          = cnt_q;
    assign period_start = ps_q;

endmodule

// File: rtl/pwm_multichannel.sv
// NUM_CH PWM channels on one shared timebase, each with a pending duty that
// is copied to the active duty at every period boundary.
module pwm_multichannel
    import pwm_pkg::*;
#(
    parameter int NUM_CH  = DEF_NUM_CH,
    parameter int CNT_W   = DEF_CNT_W,
    parameter int PRESC_W = DEF_PRESC_W,
    parameter int CH_W    = $clog2(NUM_CH)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_CH-1:0]  en_out,
    input  logic [NUM_CH-1:0]  en_pwm,
    input  logic [CNT_W-1:0]   period,
    input  logic [PRESC_W-1:0] prescale,
    input  logic               center_mode,
    input  logic               duty_wr_en,
    input  logic [CH_W-1:0]    duty_wr_ch,
    input  logic [CNT_W-1:0]   duty_wr_data,
    output logic [NUM_CH-1:0]  out,
    output logic               period_start
);

    logic [CNT_W-1:0] cnt;
    logic             tick;
    logic             boundary;
    logic             duty_load;

    pwm_timebase #(
        .CNT_W   (CNT_W),
        .PRESC_W (PRESC_W)
    ) u_timebase (
        .clk          (clk),
        .rst_n        (rst_n),
        .period       (period),
        .prescale     (prescale),
        .center_mode  (center_mode),
        .cnt          (cnt),
        .tick         (tick),
        .boundary     (boundary),
        .period_start (period_start)
    );

    assign duty_load = tick & boundary;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        logic [CNT_W-1:0] pend_q, pend_d;
        logic [CNT_W-1:0] act_q, act_d;
        logic             out_q, out_d;

        // Indices >= NUM_CH match no channel, so bad writes fall away.
        always_comb begin
            pend_d = pend_q;
            act_d  = act_q;
            if (duty_load) act_d = pend_q;
            if (duty_wr_en && duty_wr_ch == CH_W'(i)) pend_d = duty_wr_data;
            out_d = en_out[i] & (~en_pwm[i] | (cnt < act_q));
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                pend_q <= '0;
                act_q  <= '0;
                out_q  <= 1'b0;
            end else begin
                pend_q <= pend_d;
                act_q  <= act_d;
                out_q  <= out_d;
            end
        end

        assign out[i] = out_q;
    end

endmodule

// File: doc/pwm_multichannel.md
Name: pwm_multichannel

Overview:
Parametrised successor to the single-duty PWM peripheral. It provides NUM_CH channels sharing one prescaled period counter, with an independent, double-buffered duty value per channel. It supports edge-aligned or centre-aligned mode and a programmable period. It sits behind the register file, and its `out` bus drives the chip's uo_out/uio_out pins.

Parameters:
- NUM_CH, 16: number of PWM channels.
- CNT_W, 8: width of the period counter, period value and duty values.
- PRESC_W, 4: width of the prescaler reload value.
- CH_W, $clog2(NUM_CH): width of the channel index (derived; not overridden).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- en_out  in  NUM_CH  per-channel output enable; 0 forces the output low.
- en_pwm  in  NUM_CH  per-channel PWM enable; 0 with en_out=1 forces the output high.
- period  in  CNT_W  requested period top value P (shadowed).
- prescale  in  PRESC_W  requested tick divider D; one tick every D+1 clocks.
- center_mode  in  1  0 = edge-aligned, 1 = centre-aligned (shadowed).
- duty_wr_en  in  1  single-cycle duty write strobe.
- duty_wr_ch  in  CH_W  channel index for the write.
- duty_wr_data  in  CNT_W  duty value for the write.
- out  out  NUM_CH  registered PWM outputs.
- period_start  out  1  one-clock pulse at each period boundary.

Behaviour:
- Reset (async, rst_n=0):
  - prescaler, counter, direction, pending duty, active duty and shadow period/mode all clear to 0.
  - out = 0, period_start = 0.
- Prescaler:
  - Counts 0..prescale, using the live `prescale` input.
  - A tick occurs in the cycle it equals prescale; it then wraps to 0.
  - D=0 gives a tick every clock.
- Edge mode:
  - On each tick, cnt goes 0,1,..,P_act then back to 0.
  - Period = (P_act+1) ticks.
- Centre mode:
  - On each tick, cnt goes 0 up to P_act, then P_act-1 down to 1, then back to 0.
  - Period = 2*P_act ticks.
  - P_act=0 degenerates to cnt stuck at 0, with a boundary on every tick.
- Boundary: a tick on which cnt goes to 0, or stays at 0 when P_act=0. On that clock edge:
  - active duty[i] <= pending duty[i] for all channels.
  - P_act <= period and mode_act <= center_mode.
  - cnt <= 0 and direction <= up.
  - period_start is high during the cycle after the boundary edge, for exactly one clock.
- Duty writes:
  - With duty_wr_en=1 and duty_wr_ch < NUM_CH, pending duty[duty_wr_ch] <= duty_wr_data.
  - An out-of-range index is ignored.
  - A write in the same cycle as a boundary lands in pending only. The boundary load uses the pre-write pending value, and the new value takes effect at the next boundary.
- Output, per channel i, registered so it follows cnt by one clock:
  - en_out[i]=0 → 0.
  - en_out[i]=1 and en_pwm[i]=0 → 1.
  - Otherwise → (cnt < duty_act[i]).
- Duty boundaries:
  - duty=0 gives constant 0.
  - In edge mode, duty ≥ P_act+1 gives constant 1; high time = min(duty, P_act+1) ticks per period.
  - In centre mode, high time = 2*duty−1 ticks for 1 ≤ duty ≤ P_act, and constant 1 for duty > P_act. The high pulse is centred on cnt=0.
- Live vs shadowed inputs:
  - en_out/en_pwm take effect on the next clock and are not shadowed.
  - period/center_mode changes mid-period are invisible until the next boundary.
- After reset release, P_act=0, so the first tick is a boundary. Registers written before release are therefore adopted at the first tick.

Decomposition:
- Package pwm_pkg holds:
  - the mode encoding (PWM_EDGE=1'b0, PWM_CENTER=1'b1);
  - default parameter constants;
  - a function computing the next counter/direction state.
- Sub-module pwm_timebase contains the prescaler, counter, direction flag, shadow period/mode and boundary pulse. It exports cnt, tick and boundary.
- The top level holds the per-channel pending/active duty arrays and the output comparators in a generate loop.

Test Plan:
1. Edge-mode waveform. Setup: reset; prescale=0, period=9, edge mode; duty ch0=3; en_out=en_pwm=1.
   - Expect: after the first boundary, out[0] is high 3 clocks and low 7, repeating every 10 clocks.
   - Expect: period_start pulses every 10 clocks.
2. Prescaler and duty limits. Setup: prescale=3, period=4, duty ch1=0, duty ch2=5.
   - Expect: period = 20 clocks.
   - Expect: out[1] constant 0 and out[2] constant 1.
3. Centre mode. Setup: period=4, centre mode, duty ch3=2, prescale=0.
   - Expect: period 8 clocks; out[3] high 3 clocks centred on cnt=0, low 5.
4. Double buffering. Steps: mid-period, write ch0=8 with period=9; separately, write ch0 in the boundary cycle itself.
   - Expect: the old duty holds until the next boundary, then the new duty applies.
   - Expect: the same-cycle write applies one boundary later.
5. Enables and bad index. Steps: en_out[4]=0 with en_pwm[4]=1; then en_out[5]=1 with en_pwm[5]=0; then a write with duty_wr_ch=NUM_CH (wider CH_W build).
   - Expect: out[4]=0 and out[5]=1 one clock after the change.
   - Expect: the out-of-range write leaves all duties unchanged.
6. Reset mid-period. Step: assert rst_n=0 while outputs are high.
   - Expect: out=0 and period_start=0 immediately (asynchronous), with all duties cleared.
   - Expect: after release, outputs stay 0 until duties are rewritten.
